// File: rtl/gtp_rx_align_pkg.sv
// Shared types and constants for the GTP RX word-alignment controller.
package gtp_rx_align_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEARCH     = 3'd1,
        SLIDE      = 3'd2,
        SLIDE_WAIT = 3'd3,
        VERIFY     = 3'd4,
        LOCKED     = 3'd5,
        RESET      = 3'd6
    } align_state_e;

    localparam logic [19:0] DEFAULT_SYNC_PATTERN = 20'hBC3A5;
    localparam int          CNT_W                = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gtp_rx_align_ctrl.sv
// Word-alignment controller: hunts for the frame header, slides the GT until it lands on a
// word boundary, verifies and holds lock, and requests a GT reset after a failed full sweep.
module gtp_rx_align_ctrl
    import gtp_rx_align_pkg::*;
#(
    parameter int unsigned       DATA_W       = 20,
    parameter logic [DATA_W-1:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN,
    parameter int unsigned       FRAME_LEN    = 16,
    parameter int unsigned       SLIDE_GAP    = 32,
    parameter int unsigned       LOCK_CNT     = 8,
    parameter int unsigned       UNLOCK_MISS  = 4,
    parameter int unsigned       RST_HOLD     = 16
) (
    input  logic              data_clk,
    input  logic              rx_reset_n,
    input  logic              gt_rx_ready,
    input  logic [DATA_W-1:0] gt_rx_data,
    output logic              rxslide,
    output logic              reset_req,
    output logic              aligned,
    output logic              frame_start,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [4:0]        slide_cnt,
    output logic [15:0]       miss_cnt,
    output logic [2:0]        state_out
);

    localparam int                WCNT_W      = $clog2(FRAME_LEN);
    localparam logic [WCNT_W-1:0] WCNT_LAST   = WCNT_W'(FRAME_LEN - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  SEARCH_LAST = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(SLIDE_GAP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(RST_HOLD - 1);
    localparam logic [4:0]        SLIDE_MAX   = 5'(DATA_W - 1);
    localparam logic [7:0]        GOOD_TGT    = 8'(LOCK_CNT);
    localparam logic [7:0]        MISS_TGT    = 8'(UNLOCK_MISS);

    align_state_e      state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_next_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        good_q, good_d, misses_q, misses_d;
    logic [4:0]        slide_cnt_q, slide_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;
    logic              rxslide_q, rxslide_d;
    logic              reset_req_q, aligned_q, frame_start_q, data_out_valid_q;
    logic [DATA_W-1:0] data_out_q;
    logic              match_s, header_s, aligned_d;

    assign match_s     = (gt_rx_data == SYNC_PATTERN);
    assign header_s    = (wcnt_q == '0) && match_s;
    assign wcnt_next_s = (wcnt_q == WCNT_LAST) ? '0 : wcnt_q + WCNT_ONE;
    assign aligned_d   = (state_d == LOCKED);

    // Next-state logic for the FSM and its counters.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        cnt_d       = cnt_q;
        good_d      = good_q;
        misses_d    = misses_q;
        slide_cnt_d = slide_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        rxslide_d   = 1'b0;
        if (!gt_rx_ready) begin
            state_d     = IDLE;
            slide_cnt_d = 5'd0;
            wcnt_d      = '0;
            cnt_d       = '0;
            good_d      = 8'd0;
            misses_d    = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = SEARCH;
                    slide_cnt_d = 5'd0;
                    wcnt_d      = '0;
                    cnt_d       = '0;
                end
                SEARCH: begin
                    if (match_s) begin
                        state_d = VERIFY;
                        good_d  = 8'd1;
                        wcnt_d  = WCNT_ONE;
                    end else if (cnt_q == SEARCH_LAST) begin
                        state_d = SLIDE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                SLIDE: begin
                    cnt_d = '0;
                    if (slide_cnt_q == SLIDE_MAX) begin
                        state_d = RESET;
                    end else begin
                        state_d     = SLIDE_WAIT;
                        rxslide_d   = 1'b1;
                        slide_cnt_d = slide_cnt_q + 5'd1;
                    end
                end
                // Data is ignored here, including a match on the expiry cycle.
                SLIDE_WAIT: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                VERIFY: begin
                    wcnt_d = wcnt_next_s;
                    if (wcnt_q == '0) begin
                        if (match_s) begin
                            good_d = good_q + 8'd1;
                            if ((good_q + 8'd1) == GOOD_TGT) begin
                                state_d  = LOCKED;
                                misses_d = 8'd0;
                            end else begin
                                state_d = VERIFY;
                            end
                        end else begin
                            state_d = SLIDE;
                        end
                    end else begin
                        state_d = VERIFY;
                    end
                end
                LOCKED: begin
                    wcnt_d = wcnt_next_s;
                    if (wcnt_q == '0) begin
                        if (match_s) begin
                            misses_d = 8'd0;
                        end else if ((misses_q + 8'd1) == MISS_TGT) begin
                            state_d    = SEARCH;
                            cnt_d      = '0;
                            misses_d   = 8'd0;
                            miss_cnt_d = sat_inc16(miss_cnt_q);
                        end else begin
                            misses_d = misses_q + 8'd1;
                        end
                    end else begin
                        misses_d = misses_q;
                    end
                end
                RESET: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge data_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            cnt_q       <= '0;
            good_q      <= 8'd0;
            misses_q    <= 8'd0;
            slide_cnt_q <= 5'd0;
            miss_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            misses_q    <= misses_d;
            slide_cnt_q <= slide_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Output registers, all aligned to the data word they describe.
    always_ff @(posedge data_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            rxslide_q        <= 1'b0;
            reset_req_q      <= 1'b0;
            aligned_q        <= 1'b0;
            frame_start_q    <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            rxslide_q        <= rxslide_d;
            reset_req_q      <= (state_d == RESET);
            aligned_q        <= aligned_d;
            frame_start_q    <= aligned_d && header_s;
            data_out_q       <= gt_rx_data;
            data_out_valid_q <= aligned_d && !header_s;
        end
    end

    assign rxslide        = rxslide_q;
    assign reset_req      = reset_req_q;
    assign aligned        = aligned_q;
    assign frame_start    = frame_start_q;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign slide_cnt      = slide_cnt_q;
    assign miss_cnt       = miss_cnt_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_gtp_rx_align_ctrl.sv
// Bench for gtp_rx_align_ctrl: a GT model that rotates the word stream one bit per rxslide
// (two cycles after the pulse), table-driven alignment scenarios, and hand-written corner cases.
module tb_gtp_rx_align_ctrl;

    logic        data_clk;
    logic        rx_reset_n;
    logic        gt_rx_ready;
    logic [19:0] gt_rx_data;
    logic        rxslide, reset_req, aligned, frame_start, data_out_valid;
    logic [19:0] data_out;
    logic [4:0]  slide_cnt;
    logic [15:0] miss_cnt;
    logic [2:0]  state_out;

    gtp_rx_align_ctrl dut (
        .data_clk       (data_clk),
        .rx_reset_n     (rx_reset_n),
        .gt_rx_ready    (gt_rx_ready),
        .gt_rx_data     (gt_rx_data),
        .rxslide        (rxslide),
        .reset_req      (reset_req),
        .aligned        (aligned),
        .frame_start    (frame_start),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .slide_cnt      (slide_cnt),
        .miss_cnt       (miss_cnt),
        .state_out      (state_out)
    );

    initial data_clk = 1'b0;
    always #5 data_clk = ~data_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int rot;
        int period;
        int budget;
        int exp_aligned;
        int exp_pulses;
        int exp_slide_cnt;
    } scn_t;

    localparam logic [19:0] PAT = 20'hBC3A5;

    int   total = 0;
    int   bad   = 0;
    int   k, period, rot, corrupt_left, cyc;
    int   pulses, last_pulse, b2b_err, gap_err, lat_err;
    bit   prev_rx, ever_aligned, hdr_corrupted_now;
    bit   [1:0] hist;
    scn_t tbl[5];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [19:0] rotl1(input logic [19:0] w);
        return {w[18:0], w[19]};
    endfunction

    // One data_clk cycle: drive the next GT word, then sample just after the edge.
    task automatic tick();
        logic [19:0] w;
        hdr_corrupted_now = 1'b0;
        if (period != 0 && (k % period) == 0) begin
            if (corrupt_left > 0) begin
                w = PAT ^ 20'h00001;
                corrupt_left--;
                hdr_corrupted_now = 1'b1;
            end else begin
                w = PAT;
            end
        end else begin
            w = {12'h000, 8'(k)};
        end
        for (int i = 0; i < rot; i++) w = rotl1(w);
        gt_rx_data = w;
        @(posedge data_clk);
        #1;
        cyc++;
        k++;
        if (rx_reset_n && data_out !== w) lat_err++;
        if (rxslide) begin
            pulses++;
            if (prev_rx) b2b_err++;
            if (last_pulse >= 0 && (cyc - last_pulse) < 32) gap_err++;
            last_pulse = cyc;
        end
        prev_rx = rxslide;
        if (aligned) ever_aligned = 1'b1;
        if (hist[1]) rot = (rot == 0) ? 19 : rot - 1;
        hist = {hist[0], rxslide};
    endtask

    task automatic restart(input int r, input int p);
        gt_rx_ready = 1'b0;
        tick();
        tick();
        hist = 2'b00;
        prev_rx = 1'b0;
        rot = r;
        period = p;
        k = 1;
        corrupt_left = 0;
        pulses = 0;
        last_pulse = -1;
        ever_aligned = 1'b0;
        gt_rx_ready = 1'b1;
    endtask

    task automatic run_scn(input int idx);
        int fs_cnt, fs_err, v_err;
        restart(tbl[idx].rot, tbl[idx].period);
        for (int i = 0; i < tbl[idx].budget && !aligned; i++) tick();
        check($sformatf("s%0d_aligned", idx), aligned, tbl[idx].exp_aligned);
        check($sformatf("s%0d_ever_aligned", idx), ever_aligned, tbl[idx].exp_aligned);
        if (tbl[idx].exp_pulses >= 0)
            check($sformatf("s%0d_pulses", idx), pulses, tbl[idx].exp_pulses);
        if (tbl[idx].exp_slide_cnt >= 0)
            check($sformatf("s%0d_slide_cnt", idx), slide_cnt, tbl[idx].exp_slide_cnt);
        if (tbl[idx].exp_aligned == 1) begin
            fs_cnt = 0;
            fs_err = 0;
            v_err  = 0;
            for (int i = 0; i < 32; i++) begin
                tick();
                fs_cnt += int'(frame_start);
                if (frame_start != (data_out == PAT)) fs_err++;
                if (data_out_valid != !frame_start) v_err++;
            end
            check($sformatf("s%0d_frame_starts", idx), fs_cnt, 2);
            check($sformatf("s%0d_frame_start_pos", idx), fs_err, 0);
            check($sformatf("s%0d_valid", idx), v_err, 0);
        end
    endtask

    initial begin
        int  hi, early_drop, lost;
        bit  done, found;

        tbl[0] = '{rot: 0,  period: 16, budget: 400,  exp_aligned: 1, exp_pulses: 0,  exp_slide_cnt: 0};
        tbl[1] = '{rot: 5,  period: 16, budget: 1000, exp_aligned: 1, exp_pulses: 5,  exp_slide_cnt: 5};
        tbl[2] = '{rot: 1,  period: 16, budget: 600,  exp_aligned: 1, exp_pulses: 1,  exp_slide_cnt: 1};
        tbl[3] = '{rot: 19, period: 16, budget: 2500, exp_aligned: 1, exp_pulses: 19, exp_slide_cnt: 19};
        tbl[4] = '{rot: 0,  period: 17, budget: 600,  exp_aligned: 0, exp_pulses: -1, exp_slide_cnt: -1};

        cyc = 0; k = 0; period = 16; rot = 0; corrupt_left = 0; hist = 2'b00;
        pulses = 0; last_pulse = -1; b2b_err = 0; gap_err = 0; lat_err = 0;
        prev_rx = 1'b0; ever_aligned = 1'b0;
        rx_reset_n  = 1'b0;
        gt_rx_ready = 1'b0;
        gt_rx_data  = 20'h00000;
        repeat (3) @(posedge data_clk);
        #1;
        check("reset_outputs",
              {rxslide, reset_req, aligned, frame_start, data_out, data_out_valid, slide_cnt, miss_cnt, state_out}, 0);
        #3;
        rx_reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_scn(i);
        check("no_back_to_back_slides", b2b_err, 0);
        check("slide_gap", gap_err, 0);

        // Header loss: three corrupted headers keep lock, four drop it.
        run_scn(0);
        check("miss_cnt_before", miss_cnt, 0);
        corrupt_left = 3;
        lost = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (!aligned) lost++;
        end
        check("three_misses_keep_lock", lost, 0);
        check("three_misses_miss_cnt", miss_cnt, 0);
        corrupt_left = 4;
        early_drop = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (hdr_corrupted_now && corrupt_left == 0) begin
                check("fourth_miss_aligned", aligned, 0);
                check("fourth_miss_state", state_out, 1);
                check("fourth_miss_miss_cnt", miss_cnt, 1);
                done = 1'b1;
            end else if (!aligned) begin
                early_drop++;
            end
        end
        check("fourth_miss_reached", done, 1);
        check("no_early_drop", early_drop, 0);

        // No pattern at all: full sweep, then a timed reset request.
        restart(0, 0);
        b2b_err = 0;
        for (int i = 0; i < 3000 && !reset_req; i++) tick();
        check("sweep_reset_req", reset_req, 1);
        check("sweep_pulses", pulses, 19);
        check("sweep_slide_cnt", slide_cnt, 19);
        check("sweep_no_back_to_back", b2b_err, 0);
        hi = 0;
        for (int i = 0; i < 64 && reset_req; i++) begin
            hi++;
            tick();
        end
        check("reset_req_cycles", hi, 16);
        check("after_reset_idle", state_out, 0);
        tick();
        check("rehunt_search", state_out, 1);
        check("rehunt_slide_cnt", slide_cnt, 0);

        // Ready dropped while in SLIDE: the pending pulse must never appear.
        restart(3, 16);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (state_out == 3'd2) found = 1'b1;
        end
        check("reached_slide", found, 1);
        gt_rx_ready = 1'b0;
        tick();
        check("slide_truncated_rxslide", rxslide, 0);
        check("slide_truncated_state", state_out, 0);

        // Ready dropped mid SLIDE_WAIT.
        restart(3, 16);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (state_out == 3'd3) found = 1'b1;
        end
        check("reached_slide_wait", found, 1);
        repeat (5) tick();
        gt_rx_ready = 1'b0;
        tick();
        check("wait_drop_state", state_out, 0);
        check("wait_drop_aligned", aligned, 0);
        check("wait_drop_slide_cnt", slide_cnt, 0);

        // Ready dropped while locked: miss_cnt is held.
        run_scn(0);
        gt_rx_ready = 1'b0;
        tick();
        check("locked_drop_state", state_out, 0);
        check("locked_drop_aligned", aligned, 0);
        check("locked_drop_miss_cnt", miss_cnt, 1);

        // Asynchronous reset while locked clears outputs without a clock edge.
        run_scn(0);
        #2;
        rx_reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {rxslide, reset_req, aligned, frame_start, data_out, data_out_valid, slide_cnt, miss_cnt, state_out}, 0);
        #1;
        rx_reset_n = 1'b1;
        gt_rx_ready = 1'b0;
        tick();

        check("data_out_latency", lat_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
